// File: rtl/hilo_unit.sv
// hilo_unit: owns the architectural HI/LO register pair.
// It carries EX-stage HI/LO writes (MULT, MULTU, MTHI, MTLO) through the MEM
// and WB slots. Each write commits at WB. The unit forwards the youngest pending
// value back to the ALU for MFHI/MFLO.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   ex_hi, ex_lo       HI/LO values from the ALU (EX stage)
//   ex_we_hi, ex_we_lo EX instruction writes HI / LO
//   stall_m, stall_w   hold the MEM / WB slot
//   flush_m, flush_w   kill the MEM / WB slot
//   hi_rd, lo_rd       forwarded HI/LO to the ALU
//   hi_arch, lo_arch   architectural HI/LO
//   pending            any valid write in the MEM or WB slot
module hilo_unit #(
  parameter int WIDTH  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ex_hi,
  input  logic [WIDTH-1:0] ex_lo,
  input  logic             ex_we_hi,
  input  logic             ex_we_lo,
  input  logic             stall_m,
  input  logic             stall_w,
  input  logic             flush_m,
  input  logic             flush_w,
  output logic [WIDTH-1:0] hi_rd,
  output logic [WIDTH-1:0] lo_rd,
  output logic [WIDTH-1:0] hi_arch,
  output logic [WIDTH-1:0] lo_arch,
  output logic             pending
);

  logic             m_we_hi, m_we_lo;
  logic [WIDTH-1:0] m_hi, m_lo;
  logic             w_we_hi, w_we_lo;
  logic [WIDTH-1:0] w_hi, w_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

  // A MEM entry that is stalled stays in MEM.
  // A MEM entry that is killed is discarded.
  // In both cases the WB slot must not receive a copy of that entry.
  logic m_blocked;
  assign m_blocked = stall_m | flush_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_we_hi <= 1'b0;
      m_we_lo <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      w_we_hi <= 1'b0;
      w_we_lo <= 1'b0;
      w_hi    <= '0;
      w_lo    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // MEM slot
      if (flush_m) begin
        m_we_hi <= 1'b0;
        m_we_lo <= 1'b0;
        m_hi    <= '0;
        m_lo    <= '0;
      end else if (!stall_m) begin
        m_we_hi <= ex_we_hi;
        m_we_lo <= ex_we_lo;
        m_hi    <= ex_hi;
        m_lo    <= ex_lo;
      end

      // WB slot
      if (flush_w) begin
        w_we_hi <= 1'b0;
        w_we_lo <= 1'b0;
        w_hi    <= '0;
        w_lo    <= '0;
      end else if (!stall_w) begin
        if (m_blocked) begin
          w_we_hi <= 1'b0;
          w_we_lo <= 1'b0;
          w_hi    <= '0;
          w_lo    <= '0;
        end else begin
          w_we_hi <= m_we_hi;
          w_we_lo <= m_we_lo;
          w_hi    <= m_hi;
          w_lo    <= m_lo;
        end
      end

      // Commit; HI and LO are independent
      if (!stall_w && !flush_w) begin
        if (w_we_hi) hi_q <= w_hi;
        if (w_we_lo) lo_q <= w_lo;
      end
    end
  end

  // The forwarding path uses registered slot state only.
  // This keeps the ex_* to hi_rd/lo_rd path free of combinational logic.
  always_comb begin
    hi_rd = hi_q;
    lo_rd = lo_q;
    if (FWD_EN) begin
      if (m_we_hi)      hi_rd = m_hi;
      else if (w_we_hi) hi_rd = w_hi;
      if (m_we_lo)      lo_rd = m_lo;
      else if (w_we_lo) lo_rd = w_lo;
    end
  end

  assign hi_arch = hi_q;
  assign lo_arch = lo_q;
  assign pending = m_we_hi | m_we_lo | w_we_hi | w_we_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit.
// Each step queues its expected outputs. The queued entry is popped and
// compared one time unit after the following clock edge.
// A second instance with FWD_EN=0 shares the same stimulus.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_hi = '0, ex_lo = '0;
  logic        ex_we_hi = 1'b0, ex_we_lo = 1'b0;
  logic        stall_m = 1'b0, stall_w = 1'b0, flush_m = 1'b0, flush_w = 1'b0;
  logic [31:0] hi_rd, lo_rd, hi_arch, lo_arch;
  logic        pending;
  logic [31:0] hi_rd0, lo_rd0, hi_arch0, lo_arch0;
  logic        pending0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_we_hi(ex_we_hi), .ex_we_lo(ex_we_lo),
    .stall_m(stall_m), .stall_w(stall_w), .flush_m(flush_m), .flush_w(flush_w),
    .hi_rd(hi_rd), .lo_rd(lo_rd), .hi_arch(hi_arch), .lo_arch(lo_arch),
    .pending(pending)
  );

  hilo_unit #(.WIDTH(32), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_we_hi(ex_we_hi), .ex_we_lo(ex_we_lo),
    .stall_m(stall_m), .stall_w(stall_w), .flush_m(flush_m), .flush_w(flush_w),
    .hi_rd(hi_rd0), .lo_rd(lo_rd0), .hi_arch(hi_arch0), .lo_arch(lo_arch0),
    .pending(pending0)
  );

  typedef struct {
    logic [31:0] hi_rd, lo_rd, hi_arch, lo_arch;
    logic        pending;
    logic        chk0;
    logic [31:0] hi_rd0;
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;
  logic track = 1'b0;
  int   hi_changes = 0;
  logic [31:0] hi_prev = '0;

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l,
                              input logic [31:0] ha, input logic [31:0] la,
                              input logic p, input logic c0, input logic [31:0] h0);
    exp_t e;
    e.hi_rd = h; e.lo_rd = l; e.hi_arch = ha; e.lo_arch = la;
    e.pending = p; e.chk0 = c0; e.hi_rd0 = h0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step%0d %s observed=%h expected=%h", step_no, tag, obs, exp);
    end
  endtask

  task automatic cyc(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    x = sb.pop_front();
    chk("hi_rd",   hi_rd,   x.hi_rd);
    chk("lo_rd",   lo_rd,   x.lo_rd);
    chk("hi_arch", hi_arch, x.hi_arch);
    chk("lo_arch", lo_arch, x.lo_arch);
    chk("pending", {31'b0, pending}, {31'b0, x.pending});
    if (x.chk0) begin
      chk("hi_rd_nofwd",   hi_rd0,  x.hi_rd0);
      chk("lo_rd_nofwd",   lo_rd0,  x.lo_rd);
      chk("pending_nofwd", {31'b0, pending0}, {31'b0, x.pending});
    end
    if (track && hi_arch !== hi_prev) hi_changes++;
    hi_prev = hi_arch;
  endtask

  initial begin
    // Reset and MTHI
    rst = 1'b1;
    cyc(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    rst = 1'b0;
    ex_we_hi = 1'b1; ex_hi = 32'h12345678;
    cyc(mk(32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0));
    ex_we_hi = 1'b0; ex_hi = 32'h0;
    cyc(mk(32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0));
    cyc(mk(32'h12345678, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b1, 32'h12345678));

    // MULT followed back-to-back by MTLO
    ex_we_hi = 1'b1; ex_we_lo = 1'b1; ex_hi = 32'hFFFFFFFF; ex_lo = 32'h2;
    cyc(mk(32'hFFFFFFFF, 32'h2, 32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0));
    ex_we_hi = 1'b0; ex_lo = 32'hAAAA0000;
    cyc(mk(32'hFFFFFFFF, 32'hAAAA0000, 32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0));
    ex_we_lo = 1'b0;
    cyc(mk(32'hFFFFFFFF, 32'hAAAA0000, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b0, 32'h0));
    cyc(mk(32'hFFFFFFFF, 32'hAAAA0000, 32'hFFFFFFFF, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));

    // MTHI held in MEM for three cycles, WB sees bubbles
    ex_we_hi = 1'b1; ex_hi = 32'h1;
    cyc(mk(32'h1, 32'hAAAA0000, 32'hFFFFFFFF, 32'hAAAA0000, 1'b1, 1'b0, 32'h0));
    ex_we_hi = 1'b0; stall_m = 1'b1;
    hi_prev = hi_arch; track = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(mk(32'h1, 32'hAAAA0000, 32'hFFFFFFFF, 32'hAAAA0000, 1'b1, 1'b0, 32'h0));
    stall_m = 1'b0;
    cyc(mk(32'h1, 32'hAAAA0000, 32'hFFFFFFFF, 32'hAAAA0000, 1'b1, 1'b0, 32'h0));
    cyc(mk(32'h1, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));
    cyc(mk(32'h1, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));
    track = 1'b0;
    chk("hi_arch_change_count", hi_changes, 32'd1);

    // MTHI killed in MEM
    ex_we_hi = 1'b1; ex_hi = 32'h55;
    cyc(mk(32'h55, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b1, 1'b0, 32'h0));
    ex_we_hi = 1'b0; ex_hi = 32'h0; flush_m = 1'b1;
    cyc(mk(32'h1, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));
    flush_m = 1'b0;
    cyc(mk(32'h1, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));
    cyc(mk(32'h1, 32'hAAAA0000, 32'h1, 32'hAAAA0000, 1'b0, 1'b0, 32'h0));

    // Clean reset, then MTLO killed in WB
    rst = 1'b1;
    cyc(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    rst = 1'b0;
    ex_we_lo = 1'b1; ex_lo = 32'h77;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    ex_we_lo = 1'b0;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    flush_w = 1'b1;
    cyc(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    flush_w = 1'b0;

    // MTLO held in WB for two cycles
    ex_we_lo = 1'b1;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    ex_we_lo = 1'b0;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    stall_w = 1'b1;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    stall_w = 1'b0;
    cyc(mk(32'h0, 32'h77, 32'h0, 32'h77, 1'b0, 1'b0, 32'h0));

    // Reset with both slots valid, overriding stall/flush and an EX write
    ex_we_hi = 1'b1; ex_hi = 32'hA;
    cyc(mk(32'hA, 32'h77, 32'h0, 32'h77, 1'b1, 1'b0, 32'h0));
    ex_we_hi = 1'b0; ex_we_lo = 1'b1; ex_lo = 32'hB;
    cyc(mk(32'hA, 32'hB, 32'h0, 32'h77, 1'b1, 1'b0, 32'h0));
    rst = 1'b1; stall_w = 1'b1; flush_m = 1'b1;
    cyc(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    rst = 1'b0; stall_w = 1'b0; flush_m = 1'b0; ex_we_lo = 1'b0; ex_lo = 32'h0;
    cyc(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
